// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronises and filters the raw lines, deserialises
// device-to-host frames and turns Set-2 make/break codes into toggle-strobed
// ps2_key events. Define PS2_KEY_RX_ERRCNT_EN to add the err_cnt error counter.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for a start edge (data low on a clock falling edge)
// S_DATA | shifting in the 8 data bits, LSB first
// S_PARITY | capturing the odd-parity bit
// S_STOP | checking the stop bit and parity, handing the byte to decode
module ps2_key_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 6400
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key
`ifdef PS2_KEY_RX_ERRCNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [1:0]      clk_sync;
  logic [1:0]      data_sync;
  logic            clk_filt;
  logic            data_filt;
  logic            clk_filt_d;
  logic [7:0]      clk_fcnt;
  logic [7:0]      data_fcnt;
  logic            fall;

  state_t          state, state_nxt;
  logic [2:0]      bit_cnt, bit_cnt_nxt;
  logic [7:0]      shift, shift_nxt;
  logic            par_bit, par_nxt;
  logic [TO_W-1:0] to_cnt, to_cnt_nxt;
  logic            to_hit;
  logic            byte_ok;
  logic            frame_err;

  logic            ext;
  logic            brk;
  logic [2:0]      skip;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // A level must differ from the filtered value for FILTER_LEN cycles in a row.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt <= 1'b1;
      clk_fcnt <= '0;
    end else if (clk_sync[1] == clk_filt) begin
      clk_fcnt <= '0;
    end else if (clk_fcnt == 8'(FILTER_LEN - 1)) begin
      clk_filt <= clk_sync[1];
      clk_fcnt <= '0;
    end else begin
      clk_fcnt <= clk_fcnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_filt <= 1'b1;
      data_fcnt <= '0;
    end else if (data_sync[1] == data_filt) begin
      data_fcnt <= '0;
    end else if (data_fcnt == 8'(FILTER_LEN - 1)) begin
      data_filt <= data_sync[1];
      data_fcnt <= '0;
    end else begin
      data_fcnt <= data_fcnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) clk_filt_d <= 1'b1;
    else          clk_filt_d <= clk_filt;
  end

  assign fall   = clk_filt_d & ~clk_filt;
  assign to_hit = (state != S_IDLE) && !fall && (to_cnt == TO_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
      par_bit <= par_nxt;
      to_cnt  <= to_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    par_nxt     = par_bit;
    byte_ok     = 1'b0;
    frame_err   = 1'b0;
    if (state == S_IDLE || fall) to_cnt_nxt = '0;
    else                         to_cnt_nxt = to_cnt + TO_W'(1);

    case (state)
      S_IDLE: begin
        if (fall && !data_filt) begin
          state_nxt   = S_DATA;
          bit_cnt_nxt = '0;
        end
      end
      S_DATA: begin
        if (fall) begin
          shift_nxt = {data_filt, shift[7:1]};
          if (bit_cnt == 3'd7) state_nxt = S_PARITY;
          else                 bit_cnt_nxt = bit_cnt + 3'd1;
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_nxt   = data_filt;
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          state_nxt = S_IDLE;
          if (data_filt && (^{shift, par_bit})) byte_ok   = 1'b1;
          else                                  frame_err = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Stalled frame: drop the partial byte, leave the prefix flags alone.
    if (to_hit) begin
      state_nxt  = S_IDLE;
      to_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps2_key <= '0;
      ext     <= 1'b0;
      brk     <= 1'b0;
      skip    <= '0;
    end else if (frame_err) begin
      ext  <= 1'b0;
      brk  <= 1'b0;
      skip <= '0;
    end else if (byte_ok) begin
      if (skip != 3'd0) begin
        skip <= skip - 3'd1;
      end else begin
        case (shift)
          8'hE1: begin
            skip <= 3'd7;
            ext  <= 1'b0;
            brk  <= 1'b0;
          end
          8'hE0: ext <= 1'b1;
          8'hF0: brk <= 1'b1;
          8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
            ext <= 1'b0;
            brk <= 1'b0;
          end
          default: begin
            ps2_key <= {~ps2_key[10], ~brk, ext, shift};
            ext     <= 1'b0;
            brk     <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PS2_KEY_RX_ERRCNT_EN
  // Parity/framing errors and timeouts are mutually exclusive in a cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               err_cnt <= '0;
    else if ((frame_err || to_hit) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_ps2_key_rx.sv
// Scoreboard bench for ps2_key_rx: a byte-level keyboard model predicts events,
// a monitor pops them whenever ps2_key[10] toggles.
module tb_ps2_key_rx;
  localparam int FL   = 8;
  localparam int TO   = 400;
  localparam int HALF = 20;
  localparam int GAP  = 60;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
`ifdef PS2_KEY_RX_ERRCNT_EN
  logic [7:0]  err_cnt;
  int          exp_err = 0;
`endif

  ps2_key_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key)
`ifdef PS2_KEY_RX_ERRCNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [9:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int drain_req = 0;
  int rst_req = 0;
  logic m_ext = 1'b0;
  logic m_brk = 1'b0;
  int   m_skip = 0;

  // Monitor: owns every comparison and both counters.
  initial begin
    int drain_done = 0;
    int rst_done = 0;
    logic prev_tog = 1'b0;
    logic prev_rst = 1'b0;
    logic [9:0] exp;
    forever begin
      @(negedge clk);
      if (rst_req != rst_done) begin
        total++;
        if (ps2_key !== 11'h000) begin
          bad++;
          $display("FAIL reset_state: ps2_key=%h required 000", ps2_key);
        end
        rst_done = rst_req;
      end
      if (reset_n && prev_rst && ps2_key[10] !== prev_tog) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_event: ps2_key=%h, none required", ps2_key);
        end else begin
          exp = exp_q.pop_front();
          if (ps2_key[9:0] !== exp) begin
            bad++;
            $display("FAIL event_fields: got %h required %h", ps2_key[9:0], exp);
          end
        end
      end
      if (drain_req != drain_done) begin
        total++;
        if (exp_q.size() != 0) begin
          bad++;
          $display("FAIL missing_event: pending=%0d required 0 (next %h)", exp_q.size(), exp_q[0]);
          exp_q.delete();
        end
`ifdef PS2_KEY_RX_ERRCNT_EN
        total++;
        if (err_cnt !== 8'(exp_err)) begin
          bad++;
          $display("FAIL err_cnt: got %0d required %0d", err_cnt, exp_err);
        end
`endif
        drain_done = drain_req;
      end
      prev_tog = ps2_key[10];
      prev_rst = reset_n;
    end
  end

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
`ifdef PS2_KEY_RX_ERRCNT_EN
      if (exp_err < 255) exp_err++;
`endif
    end else if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) begin m_skip = 7; m_ext = 1'b0; m_brk = 1'b0; end
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
      m_ext = 1'b0; m_brk = 1'b0;
    end else begin
      exp_q.push_back({~m_brk, m_ext, b});
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = (~^b) ^ bad_par;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    model_byte(b, !(bad_par || bad_stop));
    send_bits(frame(b, bad_par, bad_stop), 11);
    ps2_data = 1'b1;
    repeat (GAP) @(posedge clk);
    drain_req++;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i], 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] seq[$];
    int r;
    logic [7:0] b;
    bit bp, bs;

    repeat (5) @(posedge clk);
    rst_req++;
    repeat (3) @(posedge clk);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);

    seq = '{8'h1C, 8'hF0, 8'h1C};                   send_seq(seq);
    seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};     send_seq(seq);
    seq = '{8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h6B};     send_seq(seq);
    send_byte(8'h76, 1'b1, 1'b0);
    send_byte(8'h76, 1'b0, 1'b0);
    seq = '{8'hE0, 8'hAA, 8'h29};                   send_seq(seq);
    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h31, 1'b0, 1'b1);
    send_byte(8'h31, 1'b0, 1'b0);
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h05};
    send_seq(seq);

    // Stall after four data bits, then a clean frame.
    send_byte(8'hE0, 1'b0, 1'b0);
    send_bits(frame(8'h5A, 1'b0, 1'b0), 5);
    ps2_data = 1'b1;
    repeat (TO + 200) @(posedge clk);
`ifdef PS2_KEY_RX_ERRCNT_EN
    exp_err++;
`endif
    drain_req++;
    repeat (2) @(posedge clk);
    send_byte(8'h5A, 1'b0, 1'b0);

    // Short glitch on the clock line while idle.
    ps2_clk = 1'b0;
    repeat (2) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (30) @(posedge clk);
    send_byte(8'h1C, 1'b0, 1'b0);

    // Reset in the middle of a frame with a prefix pending.
    send_byte(8'hF0, 1'b0, 1'b0);
    send_bits(frame(8'h33, 1'b0, 1'b0), 6);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    rst_req++;
    repeat (3) @(posedge clk);
    m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
    exp_q.delete();
`ifdef PS2_KEY_RX_ERRCNT_EN
    exp_err = 0;
`endif
    ps2_data = 1'b1;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    send_byte(8'h4B, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 15));
      case (r)
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4:       b = 8'hE1;
        5:       b = 8'hAA;
        default: b = 8'($urandom_range(0, 255));
      endcase
      bp = 1'b0; bs = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) bp = 1'b1;
        else                           bs = 1'b1;
      end
      send_byte(b, bp, bs);
    end

    repeat (50) @(posedge clk);
    drain_req++;
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
